// File: rtl/fir_loader_pkg.sv
// Shared definitions for the FIR sample loader.
// Holds the loader state encoding, default widths and step-pattern levels,
// and the sample-source select encodings.
package fir_loader_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_STEP_HI = 40;
  localparam int DEF_STEP_LO = -40;

  localparam logic SRC_STREAM = 1'b0;
  localparam logic SRC_STEP   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_step_gen.sv
// Step-pattern sample generator (combinational).
// Ports:
//   index    - sample index within the current load
//   step_len - index of the first low-level sample
//   sample   - STEP_HI while index < step_len, otherwise STEP_LO
module fir_step_gen #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int STEP_HI = 40,
  parameter int STEP_LO = -40
) (
  input  logic [ADDR_W-1:0] index,
  input  logic [ADDR_W-1:0] step_len,
  output logic [DATA_W-1:0] sample
);

  localparam logic [DATA_W-1:0] HI = DATA_W'(STEP_HI);
  localparam logic [DATA_W-1:0] LO = DATA_W'(STEP_LO);

  assign sample = (index < step_len) ? HI : LO;

endmodule

// File: rtl/fir_sample_loader.sv
// Fills the FIR sample memory through write port A before a filter run.
// Samples come either from a valid/ready byte stream or from the internal
// step-pattern generator; sample_count bytes are written from base_addr
// upward (address wraps), then done pulses for one cycle.
// Ports:
//   clk, rst (sync, active-low)
//   start, src_sel, base_addr, sample_count, step_len - load request, latched in IDLE
//   s_valid, s_data, s_ready                          - stream input
//   mem_we, mem_addr, mem_wdata                       - registered memory write port
//   busy, done, wr_count                              - status
module fir_sample_loader
  import fir_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int STEP_HI = DEF_STEP_HI,
  parameter int STEP_LO = DEF_STEP_LO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] sample_count,
  input  logic [ADDR_W-1:0] step_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_count
);

  state_t state, state_nx;

  logic              src_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] step_q;

  logic              fire;
  logic              last;
  logic [DATA_W-1:0] step_sample;
  logic [DATA_W-1:0] wdata_nx;

  fir_step_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .STEP_HI(STEP_HI),
    .STEP_LO(STEP_LO)
  ) u_step_gen (
    .index   (wr_count),
    .step_len(step_q),
    .sample  (step_sample)
  );

  assign s_ready = (state == LOAD) && (src_q == SRC_STREAM);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // count_q is never zero in LOAD (zero-length loads go straight to DONE),
  // so count_q-1 is the index of the final write.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    wdata_nx = step_sample;
    last     = (wr_count == count_q - ADDR_W'(1));
    unique case (state)
      IDLE: begin
        if (start) state_nx = (sample_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        fire = (src_q == SRC_STEP) || s_valid;
        if (src_q == SRC_STREAM) wdata_nx = s_data;
        if (fire && last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q     <= SRC_STREAM;
      base_q    <= '0;
      count_q   <= '0;
      step_q    <= '0;
      wr_count  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= fire;
      if (state == IDLE && start) begin
        src_q    <= src_sel;
        base_q   <= base_addr;
        count_q  <= sample_count;
        step_q   <= step_len;
        wr_count <= '0;
      end
      if (fire) begin
        mem_addr  <= base_q + wr_count;
        mem_wdata <= wdata_nx;
        wr_count  <= wr_count + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_loader.sv
module tb_fir_sample_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       src_sel;
  logic [9:0] base_addr;
  logic [9:0] sample_count;
  logic [9:0] step_len;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [9:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_sample_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_sel     (src_sel),
    .base_addr   (base_addr),
    .sample_count(sample_count),
    .step_len    (step_len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .wr_count    (wr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the i-th write of a load goes to (base+i) mod 1024; its data is
  // the i-th accepted beat (stream) or 40 / -40 by comparing i with step_len.
  task automatic run_load(input string name, input bit src, input int base,
                          input int count, input int slen, input int vpct,
                          input bit poke_start, input bit full_valid);
    int idx;
    int cyc;
    bit v;
    bit fin;
    logic [7:0] d;
    logic [7:0] expd;
    start        = 1'b1;
    src_sel      = src;
    base_addr    = 10'(base);
    sample_count = 10'(count);
    step_len     = 10'(slen);
    s_valid      = 1'b0;
    tick();
    // Scramble request inputs: the load must use the latched copies.
    start        = 1'b0;
    src_sel      = ~src;
    base_addr    = 10'($urandom);
    sample_count = 10'($urandom);
    step_len     = 10'($urandom);
    chk({name, ".start_we"}, 32'(mem_we), 0);
    chk({name, ".start_busy"}, 32'(busy), 1);
    chk({name, ".start_wrcnt"}, 32'(wr_count), 0);
    chk({name, ".start_done"}, 32'(done), 32'(count == 0));
    idx = 0;
    cyc = 0;
    fin = (count == 0);
    while (!fin) begin
      chk({name, ".s_ready"}, 32'(s_ready), 32'(!src));
      if (poke_start && cyc == 1) begin
        start     = 1'b1;
        base_addr = 10'(base + 300);
      end
      d = 8'($urandom);
      if (src) begin
        v       = 1'b1;
        s_valid = 1'($urandom_range(1));
        expd    = (idx < slen) ? 8'd40 : 8'hD8;
      end else begin
        v       = full_valid || ($urandom_range(99) < vpct);
        s_valid = v;
        expd    = d;
      end
      s_data = d;
      tick();
      start = 1'b0;
      if (v) begin
        chk({name, ".we"}, 32'(mem_we), 1);
        chk({name, ".addr"}, 32'(mem_addr), 32'((base + idx) % 1024));
        chk({name, ".data"}, 32'(mem_wdata), 32'(expd));
        idx++;
      end else begin
        chk({name, ".bubble_we"}, 32'(mem_we), 0);
      end
      fin = (idx == count);
      chk({name, ".wrcnt"}, 32'(wr_count), 32'(idx));
      chk({name, ".done"}, 32'(done), 32'(fin));
      chk({name, ".busy"}, 32'(busy), 1);
      cyc++;
      if (src && !fin) chk({name, ".step_len_cycles"}, 32'(cyc < count), 1);
      if (cyc > count * 20 + 50) begin
        chk({name, ".timeout_writes"}, 32'(idx), 32'(count));
        fin = 1'b1;
      end
    end
    // DONE cycle: a beat offered here must not be taken.
    chk({name, ".done_ready"}, 32'(s_ready), 0);
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    tick();
    s_valid = 1'b0;
    chk({name, ".post_we"}, 32'(mem_we), 0);
    chk({name, ".post_busy"}, 32'(busy), 0);
    chk({name, ".post_done"}, 32'(done), 0);
    chk({name, ".post_wrcnt"}, 32'(wr_count), 32'(count));
    tick();
    chk({name, ".idle_hold_wrcnt"}, 32'(wr_count), 32'(count));
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    src_sel      = 1'b0;
    base_addr    = '0;
    sample_count = '0;
    step_len     = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    tick();
    tick();
    chk("rst.we", 32'(mem_we), 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.wdata", 32'(mem_wdata), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ready", 32'(s_ready), 0);
    chk("rst.wrcnt", 32'(wr_count), 0);
    rst = 1'b1;
    tick();

    // Beats offered while idle are ignored.
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("idle.we", 32'(mem_we), 0);

    run_load("stream4", 1'b0, 0, 4, 0, 100, 1'b0, 1'b1);
    run_load("bubbles", 1'b0, 512, 3, 0, 40, 1'b0, 1'b0);
    run_load("step100", 1'b1, 0, 100, 50, 0, 1'b0, 1'b0);
    run_load("wrap", 1'b1, 1022, 4, 4, 0, 1'b0, 1'b0);
    run_load("zero", 1'b0, 77, 0, 0, 0, 1'b0, 1'b0);
    run_load("step_all_lo", 1'b1, 1020, 8, 0, 0, 1'b0, 1'b0);
    run_load("step_all_hi", 1'b1, 5, 6, 900, 0, 1'b0, 1'b0);
    run_load("stream_wrap", 1'b0, 1019, 9, 0, 60, 1'b0, 1'b0);
    run_load("busy_start", 1'b0, 200, 6, 0, 100, 1'b1, 1'b1);
    run_load("busy_start_step", 1'b1, 40, 5, 2, 0, 1'b1, 1'b0);

    // Reset in the middle of a stream load.
    start        = 1'b1;
    src_sel      = 1'b0;
    base_addr    = 10'd100;
    sample_count = 10'd6;
    step_len     = '0;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'd11;
    tick();
    s_data = 8'd22;
    tick();
    chk("midrst.pre_wrcnt", 32'(wr_count), 2);
    s_data = 8'd33;
    rst    = 1'b0;
    tick();
    chk("midrst.we", 32'(mem_we), 0);
    chk("midrst.addr", 32'(mem_addr), 0);
    chk("midrst.wdata", 32'(mem_wdata), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.ready", 32'(s_ready), 0);
    chk("midrst.wrcnt", 32'(wr_count), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.idle_we", 32'(mem_we), 0);
      chk("midrst.idle_done", 32'(done), 0);
    end
    s_valid = 1'b0;
    run_load("after_rst", 1'b0, 100, 6, 0, 70, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
